// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types, default sizes and the edge-wrap helper for the PWM
// generator.
//   time_t  - one time count / cycle / duty / phase value
//   sedge_t - signed intermediate edge position before wrapping
//   edge_t  - one channel's edge record {rise, fall, full}
package pwm_pkg;

    localparam int PWM_WIDTH = 13;
    localparam int PWM_DEPTH = 249;
    // Two extra bits: one for the sign of p-h, one so p+(d-h) cannot overflow
    // when the cycle is close to full scale.
    localparam int EDGE_W    = PWM_WIDTH + 2;

    typedef logic [PWM_WIDTH-1:0]     time_t;
    typedef logic signed [EDGE_W-1:0] sedge_t;

    typedef struct packed {
        time_t rise;
        time_t fall;
        logic  full;
    } edge_t;

    // Fold an edge position that fell outside 0..cycle-1 back into the period.
    // Positions are never more than one period out of range.
    function automatic time_t wrap_edge(input sedge_t value, input time_t cycle);
        sedge_t cyc_s;
        sedge_t adj;
        cyc_s = sedge_t'({2'b00, cycle});
        if (value[EDGE_W-1]) begin
            adj = value + cyc_s;
        end else if (value >= cyc_s) begin
            adj = value - cyc_s;
        end else begin
            adj = value;
        end
        return adj[PWM_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/pwm_generator_channel.sv
// pwm_channel: one transducer output.
//   clk, rst_n - clock, asynchronous active-low reset
//   time_cnt   - this channel's time counter
//   buf_edge   - pending edges written by the sweep pipeline
//   pwm_out    - registered PWM bit, one cycle behind time_cnt
// The active edges only change at time_cnt == 0, so a running period is
// never cut short; the comparison in that cycle already uses the new edges.
module pwm_channel
    import pwm_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  time_t time_cnt,
    input  edge_t buf_edge,
    output logic  pwm_out
);

    edge_t act_q, act_d;
    edge_t eff;
    logic  pwm_q, pwm_d;

    always_comb begin
        eff   = (time_cnt == '0) ? buf_edge : act_q;
        act_d = eff;
        pwm_d = 1'b0;
        if (eff.full) begin
            pwm_d = 1'b1;
        end else if (eff.rise == eff.fall) begin
            pwm_d = 1'b0;                       // zero duty
        end else if (eff.rise < eff.fall) begin
            pwm_d = (time_cnt >= eff.rise) && (time_cnt < eff.fall);
        end else begin                          // pulse straddles the period end
            pwm_d = (time_cnt >= eff.rise) || (time_cnt < eff.fall);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            act_q <= act_d;
            pwm_q <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;

endmodule

// File: rtl/pwm_generator.sv
// pwm_generator: turns per-channel duty/phase into PWM bits.
//   CLK, RST_N  - clock, asynchronous active-low reset
//   TIME_CNT[i] - channel time counter, 0..CYCLE[i]-1
//   CYCLE[i]    - channel period (>= 2)
//   DUTY[i]     - high time in clocks
//   PHASE[i]    - pulse centre in clocks
//   PWM_OUT[i]  - PWM bit per channel
//   SWEEP_DONE  - pulses when the last channel's edges are written
// A sweep index visits one channel per cycle; a three-stage pipeline turns
// that channel's duty/phase into rise/fall edges and stores them in the
// channel's edge buffer, which the channel picks up at its next boundary.
module pwm_generator
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH,
    parameter int DEPTH = PWM_DEPTH
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] TIME_CNT [0:DEPTH-1],
    input  logic [WIDTH-1:0] CYCLE    [0:DEPTH-1],
    input  logic [WIDTH-1:0] DUTY     [0:DEPTH-1],
    input  logic [WIDTH-1:0] PHASE    [0:DEPTH-1],
    output logic             PWM_OUT  [0:DEPTH-1],
    output logic             SWEEP_DONE
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    typedef logic [IDX_W-1:0] idx_t;
    localparam idx_t LAST_IDX = idx_t'(DEPTH - 1);

    idx_t   k_q, k_d;

    // S1: clamped channel parameters
    time_t  s1_c_q, s1_c_d, s1_d_q, s1_d_d, s1_p_q, s1_p_d, s1_h_q, s1_h_d;
    idx_t   s1_idx_q, s1_idx_d;
    logic   s1_vld_q, s1_vld_d;

    // S2: unwrapped edges
    sedge_t s2_r_q, s2_r_d, s2_f_q, s2_f_d;
    time_t  s2_c_q, s2_c_d;
    logic   s2_full_q, s2_full_d;
    idx_t   s2_idx_q, s2_idx_d;
    logic   s2_vld_q, s2_vld_d;

    // S3: wrapped edge record written into the buffer
    edge_t  wr_edge;
    logic   wr_en;
    logic   done_q, done_d;

    time_t  cyc_in, duty_in, phase_in;

    always_comb begin
        k_d      = (k_q == LAST_IDX) ? '0 : k_q + idx_t'(1);

        cyc_in   = CYCLE[k_q];
        duty_in  = DUTY[k_q];
        phase_in = PHASE[k_q];
        s1_c_d   = cyc_in;
        s1_d_d   = (duty_in > cyc_in) ? cyc_in : duty_in;
        s1_p_d   = (phase_in >= cyc_in) ? cyc_in - time_t'(1) : phase_in;
        s1_h_d   = s1_d_d >> 1;
        s1_idx_d = k_q;
        s1_vld_d = 1'b1;

        // The pulse spans [p-h, p+(d-h)), so odd duties put the extra clock late.
        s2_r_d    = sedge_t'({2'b00, s1_p_q}) - sedge_t'({2'b00, s1_h_q});
        s2_f_d    = sedge_t'({2'b00, s1_p_q}) + sedge_t'({2'b00, s1_d_q - s1_h_q});
        s2_c_d    = s1_c_q;
        s2_full_d = (s1_d_q == s1_c_q);
        s2_idx_d  = s1_idx_q;
        s2_vld_d  = s1_vld_q;

        wr_edge.rise = wrap_edge(s2_r_q, s2_c_q);
        wr_edge.fall = wrap_edge(s2_f_q, s2_c_q);
        wr_edge.full = s2_full_q;
        // Valid bits keep the all-zero post-reset pipeline contents (which
        // would look like a full-duty channel 0) out of the buffers.
        wr_en        = s2_vld_q;
        done_d       = s2_vld_q && (s2_idx_q == LAST_IDX);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            k_q       <= '0;
            s1_c_q    <= '0;
            s1_d_q    <= '0;
            s1_p_q    <= '0;
            s1_h_q    <= '0;
            s1_idx_q  <= '0;
            s1_vld_q  <= 1'b0;
            s2_r_q    <= '0;
            s2_f_q    <= '0;
            s2_c_q    <= '0;
            s2_full_q <= 1'b0;
            s2_idx_q  <= '0;
            s2_vld_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            k_q       <= k_d;
            s1_c_q    <= s1_c_d;
            s1_d_q    <= s1_d_d;
            s1_p_q    <= s1_p_d;
            s1_h_q    <= s1_h_d;
            s1_idx_q  <= s1_idx_d;
            s1_vld_q  <= s1_vld_d;
            s2_r_q    <= s2_r_d;
            s2_f_q    <= s2_f_d;
            s2_c_q    <= s2_c_d;
            s2_full_q <= s2_full_d;
            s2_idx_q  <= s2_idx_d;
            s2_vld_q  <= s2_vld_d;
            done_q    <= done_d;
        end
    end

    assign SWEEP_DONE = done_q;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_chan
        edge_t buf_q, buf_d;

        always_comb begin
            buf_d = buf_q;
            if (wr_en && (s2_idx_q == idx_t'(gi))) begin
                buf_d = wr_edge;
            end
        end

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                buf_q <= '0;
            end else begin
                buf_q <= buf_d;
            end
        end

        // The channel reads buf_q, so a load coinciding with a write of the
        // same channel sees the old edges; the new ones wait a period.
        pwm_channel u_chan (
            .clk      (CLK),
            .rst_n    (RST_N),
            .time_cnt (TIME_CNT[gi]),
            .buf_edge (buf_q),
            .pwm_out  (PWM_OUT[gi])
        );
    end

endmodule

// File: tb/tb_pwm_generator.sv
module tb_pwm_generator;
    import pwm_pkg::*;

    localparam int W = PWM_WIDTH;
    localparam int D = PWM_DEPTH;

    logic         CLK   = 1'b0;
    logic         RST_N = 1'b0;
    logic [W-1:0] time_cnt [0:D-1];
    logic [W-1:0] cycle    [0:D-1];
    logic [W-1:0] duty     [0:D-1];
    logic [W-1:0] phase    [0:D-1];
    logic         pwm_out  [0:D-1];
    logic         sweep_done;

    int checks = 0;
    int errors = 0;

    pwm_generator #(.WIDTH(W), .DEPTH(D)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .TIME_CNT   (time_cnt),
        .CYCLE      (cycle),
        .DUTY       (duty),
        .PHASE      (phase),
        .PWM_OUT    (pwm_out),
        .SWEEP_DONE (sweep_done)
    );

    always #5 CLK = ~CLK;

    // Reference model: each channel is a parameter set (c,d,p). The sweep
    // captures channel (n-1) mod D at edge n; that capture becomes loadable
    // at boundaries strictly after edge n+2. A channel is high at time t when
    // t lies within d clocks after start = p - floor(d/2) (mod c).
    typedef struct {
        int c;
        int d;
        int p;
    } prm_t;

    prm_t   cur [D];
    prm_t   prv [D];
    prm_t   act [D];
    longint cur_rdy [D];
    bit     exp_pwm [D];
    bit     exp_sd;
    longint n_edge;
    longint sd_first;
    int     t0_pre;

    function automatic bit exp_high(input prm_t m, input int t);
        int dd, pp, start;
        if (m.c == 0) return 1'b0;
        dd = (m.d > m.c) ? m.c : m.d;
        pp = (m.p >= m.c) ? m.c - 1 : m.p;
        if (dd == m.c) return 1'b1;
        if (dd == 0) return 1'b0;
        start = ((pp - dd / 2) % m.c + m.c) % m.c;
        return (((t - start) % m.c + m.c) % m.c) < dd;
    endfunction

    task automatic model_reset();
        n_edge   = 0;
        sd_first = -1;
        exp_sd   = 1'b0;
        for (int i = 0; i < D; i++) begin
            cur[i] = '{0, 0, 0};
            prv[i] = '{0, 0, 0};
            act[i] = '{0, 0, 0};
            cur_rdy[i] = 0;
            exp_pwm[i] = 1'b0;
        end
    endtask

    task automatic step();
        int idx;
        @(posedge CLK);
        n_edge++;
        for (int i = 0; i < D; i++) begin
            if (time_cnt[i] == '0) act[i] = (cur_rdy[i] < n_edge) ? cur[i] : prv[i];
            exp_pwm[i] = exp_high(act[i], int'(time_cnt[i]));
        end
        idx = int'((n_edge - 1) % D);
        prv[idx] = cur[idx];
        cur[idx] = '{int'(cycle[idx]), int'(duty[idx]), int'(phase[idx])};
        cur_rdy[idx] = n_edge + 2;
        exp_sd = (n_edge >= D + 2) && (((n_edge - D - 2) % D) == 0);
        t0_pre = int'(time_cnt[0]);
        #1;
        for (int i = 0; i < D; i++) begin
            if (int'(time_cnt[i]) + 1 >= int'(cycle[i])) time_cnt[i] = '0;
            else time_cnt[i] = W'(int'(time_cnt[i]) + 1);
        end
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            step();
            for (int i = 0; i < D; i++) begin
                checks++;
                if (pwm_out[i] !== exp_pwm[i]) begin
                    errors++;
                    $display("FAIL pwm_out[%0d] edge %0d: got %b expected %b", i, n_edge, pwm_out[i], exp_pwm[i]);
                end
            end
            checks++;
            if (sweep_done !== exp_sd) begin
                errors++;
                $display("FAIL sweep_done edge %0d: got %b expected %b", n_edge, sweep_done, exp_sd);
            end
            if (sweep_done === 1'b1 && sd_first < 0) sd_first = n_edge;
        end
    endtask

    // Align to channel 0's boundary, then record one 100-clock period of
    // PWM_OUT[0] indexed by the time count it follows.
    task automatic measure_period(input int chg_at, input int new_duty,
                                  output int cnt, output logic [99:0] hv);
        int guard = 0;
        while (time_cnt[0] != '0 && guard < 200) begin
            run_cycles(1);
            guard++;
        end
        checks++;
        if (time_cnt[0] != '0) begin
            errors++;
            $display("FAIL align: time_cnt[0] got %0d expected 0", time_cnt[0]);
        end
        hv = '0;
        for (int s = 0; s < 100; s++) begin
            if (s == chg_at) duty[0] = W'(new_duty);
            run_cycles(1);
            hv[t0_pre] = pwm_out[0];
        end
        cnt = $countones(hv);
        $display("period ch0 duty=%0d phase=%0d high=%0d", duty[0], phase[0], cnt);
    endtask

    task automatic test_reset();
        cycle[0] = W'(100); duty[0] = '0; phase[0] = '0; time_cnt[0] = '0;
        for (int i = 1; i < D; i++) begin
            cycle[i]    = W'($urandom_range(2, 150));
            duty[i]     = W'($urandom_range(0, int'(cycle[i]) + 10));
            phase[i]    = W'($urandom_range(0, int'(cycle[i]) + 10));
            time_cnt[i] = W'($urandom_range(0, int'(cycle[i]) - 1));
        end
        repeat (3) begin
            @(posedge CLK); #1;
            for (int i = 0; i < D; i++) begin
                checks++;
                if (pwm_out[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset pwm_out[%0d]: got %b expected 0", i, pwm_out[i]);
                end
            end
            checks++;
            if (sweep_done !== 1'b0) begin
                errors++;
                $display("FAIL reset sweep_done: got %b expected 0", sweep_done);
            end
        end
        @(negedge CLK);
        RST_N = 1'b1;
        model_reset();
        run_cycles(D + 5);
        checks++;
        if (sd_first != D + 2) begin
            errors++;
            $display("FAIL first_sweep_done: got edge %0d expected %0d", sd_first, D + 2);
        end
        $display("reset release: first SWEEP_DONE at edge %0d", sd_first);
    endtask

    task automatic test_edge_pattern(input int d, input int p, input int exp_cnt,
                                     input int t_lo_a, input int t_hi_a,
                                     input int t_hi_b, input int t_lo_b);
        int cnt;
        logic [99:0] hv;
        duty[0] = W'(d); phase[0] = W'(p);
        run_cycles(D + 104);
        measure_period(-1, 0, cnt, hv);
        checks++;
        if (cnt != exp_cnt) begin
            errors++;
            $display("FAIL width d=%0d p=%0d: got %0d expected %0d", d, p, cnt, exp_cnt);
        end
        checks++;
        if (hv[t_lo_a] !== 1'b0 || hv[t_hi_a] !== 1'b1 || hv[t_hi_b] !== 1'b1 || hv[t_lo_b] !== 1'b0) begin
            errors++;
            $display("FAIL edges d=%0d p=%0d: got t%0d=%b t%0d=%b t%0d=%b t%0d=%b expected 0 1 1 0",
                     d, p, t_lo_a, hv[t_lo_a], t_hi_a, hv[t_hi_a], t_hi_b, hv[t_hi_b], t_lo_b, hv[t_lo_b]);
        end
    endtask

    task automatic test_centered();
        test_edge_pattern(50, 50, 50, 24, 25, 74, 75);
    endtask

    task automatic test_wrapped();
        test_edge_pattern(40, 5, 40, 84, 85, 24, 25);
    endtask

    task automatic test_phase_clamp();
        test_edge_pattern(10, 120, 10, 93, 94, 3, 4);
    endtask

    task automatic test_duty_limits();
        int exp_c [3] = '{0, 100, 100};
        int d_val [3] = '{0, 100, 150};
        int cnt;
        logic [99:0] hv;
        for (int j = 0; j < 3; j++) begin
            duty[0] = W'(d_val[j]); phase[0] = W'(50);
            run_cycles(D + 104);
            measure_period(-1, 0, cnt, hv);
            checks++;
            if (cnt != exp_c[j]) begin
                errors++;
                $display("FAIL duty_limit d=%0d: got %0d expected %0d", d_val[j], cnt, exp_c[j]);
            end
        end
    endtask

    task automatic test_duty_change();
        int cnt;
        int cnts [4];
        logic [99:0] hv;
        duty[0] = W'(20); phase[0] = W'(50);
        run_cycles(D + 104);
        measure_period(31, 60, cnt, hv);
        checks++;
        if (cnt != 20) begin
            errors++;
            $display("FAIL duty_change current: got %0d expected 20", cnt);
        end
        for (int j = 0; j < 4; j++) measure_period(-1, 0, cnts[j], hv);
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (!(cnts[j] == 20 || cnts[j] == 60) || (j > 0 && cnts[j - 1] == 60 && cnts[j] != 60)) begin
                errors++;
                $display("FAIL duty_change period %0d: got %0d expected 20 then 60", j, cnts[j]);
            end
        end
        checks++;
        if (cnts[3] != 60) begin
            errors++;
            $display("FAIL duty_change final: got %0d expected 60", cnts[3]);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < D; i++) begin
                duty[i]  = W'($urandom_range(0, int'(cycle[i]) + 10));
                phase[i] = W'($urandom_range(0, int'(cycle[i]) + 10));
            end
            run_cycles($urandom_range(150, 400));
            $display("random round %0d done at edge %0d", r, n_edge);
        end
    endtask

    task automatic test_back_to_back();
        int ch;
        for (int s = 0; s < 300; s++) begin
            for (int j = 0; j < 8; j++) begin
                ch = $urandom_range(0, D - 1);
                duty[ch]  = W'($urandom_range(0, int'(cycle[ch]) + 10));
                phase[ch] = W'($urandom_range(0, int'(cycle[ch]) + 10));
            end
            run_cycles(1);
        end
        run_cycles(D + 160);
        $display("back_to_back done at edge %0d", n_edge);
    endtask

    task automatic test_mid_reset();
        duty[0] = W'(100); phase[0] = W'(10);
        run_cycles(D + 104);
        checks++;
        if (pwm_out[0] !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset pwm_out[0]: got %b expected 1", pwm_out[0]);
        end
        #1 RST_N = 1'b0;
        #1;
        for (int i = 0; i < D; i++) begin
            checks++;
            if (pwm_out[i] !== 1'b0) begin
                errors++;
                $display("FAIL async_reset pwm_out[%0d]: got %b expected 0", i, pwm_out[i]);
            end
        end
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (pwm_out[0] !== 1'b0 || sweep_done !== 1'b0) begin
            errors++;
            $display("FAIL held_reset: got pwm %b done %b expected 0 0", pwm_out[0], sweep_done);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        model_reset();
        run_cycles(D + 5);
        checks++;
        if (sd_first != D + 2) begin
            errors++;
            $display("FAIL restart_sweep_done: got edge %0d expected %0d", sd_first, D + 2);
        end
        run_cycles(D + 104);
        checks++;
        if (pwm_out[0] !== 1'b1) begin
            errors++;
            $display("FAIL post_reset pwm_out[0]: got %b expected 1", pwm_out[0]);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_centered();
        test_wrapped();
        test_duty_limits();
        test_phase_clamp();
        test_duty_change();
        test_random();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
